// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the writeback, register file and issue logic.
package regfile_pkg;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 32;
    localparam int unsigned AW    = 5;

    typedef logic [AW-1:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = '0;

endpackage

// File: rtl/regfile_writeback_wb_arbiter2.sv
// Two-requester grant logic for the writeback port (ALU vs LSU).
// WB_RR_ARB_EN selects a 1-bit round-robin pointer; otherwise LSU has fixed priority.
module wb_arbiter2 (
`ifdef WB_RR_ARB_EN
    input  logic clk,
    input  logic rst_n,
`endif
    input  logic req_alu,
    input  logic req_lsu,
    output logic gnt_alu,
    output logic gnt_lsu
);

`ifdef WB_RR_ARB_EN
    // 0: ALU wins the next contended cycle, 1: LSU wins it
    logic prefer_lsu;

    always_comb begin
        gnt_alu = req_alu & ~(req_lsu & prefer_lsu);
        gnt_lsu = req_lsu & ~(req_alu & ~prefer_lsu);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer_lsu <= 1'b0;
        end else if (req_alu && req_lsu) begin
            prefer_lsu <= gnt_alu;
        end
    end
`else
    always_comb begin
        gnt_lsu = req_lsu;
        gnt_alu = req_alu & ~req_lsu;
    end
`endif

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-side initiator: ALU/LSU arbitration, busy scoreboard and
// read-during-write forwarding. Optional round-robin arbitration via WB_RR_ARB_EN.
import regfile_pkg::*;

module regfile_writeback #(
    parameter int unsigned XLEN  = regfile_pkg::XLEN,
    parameter int unsigned NREGS = regfile_pkg::NREGS,
    parameter int unsigned AW    = regfile_pkg::AW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [AW-1:0]   lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            wb_we,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            fwd1_valid,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_valid,
    output logic [XLEN-1:0] fwd2_data
);

    logic              gnt_alu;
    logic              gnt_lsu;
    logic              fire;
    logic              sel_we;
    logic [AW-1:0]     sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [2**AW-1:0]  busy_q;

    wb_arbiter2 u_arb (
`ifdef WB_RR_ARB_EN
        .clk     (clk),
        .rst_n   (rst_n),
`endif
        .req_alu (alu_valid),
        .req_lsu (lsu_valid),
        .gnt_alu (gnt_alu),
        .gnt_lsu (gnt_lsu)
    );

    always_comb begin
        alu_ready = rst_n & gnt_alu;
        lsu_ready = rst_n & gnt_lsu;
        fire      = alu_ready | lsu_ready;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
        if (lsu_ready) begin
            sel_rd   = lsu_rd;
            sel_data = lsu_data;
        end
        // x0 results are accepted but never written
        sel_we    = fire && (sel_rd != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else begin
            wb_we <= sel_we;
            if (sel_we) begin
                wb_rd   <= sel_rd;
                wb_data <= sel_data;
            end
        end
    end

    // Set has precedence over clear: the newly issued producer owns the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int unsigned i = 0; i < 2**AW; i++) begin
                if (i == 0 || i >= NREGS) begin
                    busy_q[i] <= 1'b0;
                end else if (issue_valid && issue_rd == AW'(i)) begin
                    busy_q[i] <= 1'b1;
                end else if (wb_we && wb_rd == AW'(i)) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        rs1_busy = busy_q[rs1];
        rs2_busy = busy_q[rs2];
    end

    // Register file returns old data when read and written in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd1_valid <= 1'b0;
            fwd1_data  <= '0;
            fwd2_valid <= 1'b0;
            fwd2_data  <= '0;
        end else begin
            fwd1_valid <= wb_we && (wb_rd == rs1) && (rs1 != '0);
            fwd1_data  <= wb_data;
            fwd2_valid <= wb_we && (wb_rd == rs2) && (rs2 != '0);
            fwd2_data  <= wb_data;
        end
    end

endmodule
